// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the pipeline registers that follow it.
package fetch_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// Pipeline register between two stages: load, hold and flush with NOP insertion
// whenever the slot is empty. Flush beats load, load beats hold.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    // Next slot contents; pc fields are kept when the slot empties.
    always_comb begin
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end else if (load) begin
            valid_d    = 1'b1;
            inst_d     = load_inst;
            pc_d       = load_pc;
            pc_plus4_d = load_pc + 32'd4;
        end else if (!hold) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            inst_q     <= NOP_INST;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd4;
        end else begin
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign inst     = inst_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding memory request, one-entry hold buffer
// for decode stalls, and redirect handling that drops in-flight responses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic [31:0]  hold_pc_q, hold_pc_d;

    logic         ifid_load;
    logic [31:0]  ifid_load_inst;
    logic [31:0]  ifid_load_pc;

    // Next-state, PC and IF/ID load decisions; redirect overrides everything else.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fetch_pc_d     = fetch_pc_q;
        drop_d         = drop_q;
        hold_inst_d    = hold_inst_q;
        hold_pc_d      = hold_pc_q;
        ifid_load      = 1'b0;
        ifid_load_inst = imem_rdata;
        ifid_load_pc   = fetch_pc_q;

        unique case (state_q)
            StFetch: begin
                if (imem_gnt) begin
                    fetch_pc_d = pc_q;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = StFetch;
                    end else if (!id_stall || !ifid_valid) begin
                        ifid_load = 1'b1;
                        pc_d      = fetch_pc_q + 32'd4;
                        state_d   = StFetch;
                    end else begin
                        hold_inst_d = imem_rdata;
                        hold_pc_d   = fetch_pc_q;
                        pc_d        = fetch_pc_q + 32'd4;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (!id_stall) begin
                    ifid_load      = 1'b1;
                    ifid_load_inst = hold_inst_q;
                    ifid_load_pc   = hold_pc_q;
                    state_d        = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (redirect_valid) begin
            pc_d      = align_word(redirect_pc);
            ifid_load = 1'b0;
            case (state_q)
                // A grant this cycle means a response is coming for the old PC.
                StFetch: drop_d = imem_gnt;
                StWait: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = StFetch;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                StHold:  state_d = StFetch;
                default: ;
            endcase
        end
    end

    // FSM, PC and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            drop_q      <= 1'b0;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_q      <= drop_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // Request only from the registered state so nothing is issued during reset.
    assign imem_req  = rst_n && (state_q == StFetch);
    assign imem_addr = pc_q;

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifid_load),
        .hold      (id_stall),
        .flush     (redirect_valid),
        .load_inst (ifid_load_inst),
        .load_pc   (ifid_load_pc),
        .valid     (ifid_valid),
        .inst      (ifid_inst),
        .pc        (ifid_pc),
        .pc_plus4  (ifid_pc_plus4)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the rv32i core.
- Holds the PC and issues one-outstanding-request fetches to instruction memory.
- Captures the returned word and presents instruction and PC to decode, where the immediate generator and control unit consume it.
- Handles decode stalls with a one-entry hold buffer, and handles branch/jump redirects by flushing and dropping in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset.
- NOP_INST, 32'h0000_0013: encoding of addi x0,x0,0, presented when the IF/ID slot is empty.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, always the current PC.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid, at least 1 cycle after the grant.
- imem_rdata  in  32  fetched instruction word.
- id_stall  in  1  decode cannot accept a new instruction; hold IF/ID.
- redirect_valid  in  1  branch taken or jump resolved; change PC.
- redirect_pc  in  32  target address; bits [1:0] forced to 0.
- ifid_valid  out  1  IF/ID slot holds a real instruction.
- ifid_inst  out  32  instruction to decode (NOP_INST when not valid).
- ifid_pc  out  32  PC of ifid_inst.
- ifid_pc_plus4  out  32  ifid_pc + 4, used for JAL/JALR link.

Behaviour:
Reset (asynchronous, any cycle, including mid-request):
- pc=RESET_PC, state=FETCH, drop=0.
- imem_req=0 while rst_n is low.
- ifid_valid=0, ifid_inst=NOP_INST, ifid_pc=0, ifid_pc_plus4=4.
- Hold buffer cleared.
- A memory response arriving after reset is released is discarded only if drop is set. Memory is reset together with the core.

States:
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt, record fetch_pc=pc and go to WAIT.
- WAIT:
  - imem_req=0; wait for imem_rvalid.
  - On rvalid with drop=1: discard the data, clear drop, go to FETCH.
  - On rvalid with drop=0 and ID able to accept (id_stall=0 or ifid_valid=0): load IF/ID (valid=1, inst=rdata, pc=fetch_pc, pc_plus4=fetch_pc+4), set pc=fetch_pc+4, go to FETCH.
  - On rvalid with drop=0 and ID stalled with a valid slot: write the word and fetch_pc into the hold buffer, set pc=fetch_pc+4, go to HOLD.
- HOLD:
  - imem_req=0.
  - When id_stall=0, move the buffer into IF/ID and go to FETCH.

IF/ID update rules (outside the load events above):
- id_stall=1: all ifid_* outputs hold.
- id_stall=0 with nothing loaded this cycle: ifid_valid=0, ifid_inst=NOP_INST. ifid_pc and ifid_pc_plus4 hold.

Redirect (highest priority, overrides stall):
- pc=redirect_pc & ~3.
- IF/ID flushed: valid=0, inst=NOP_INST.
- FETCH without grant: the next cycle requests the new PC.
- FETCH with grant in the same cycle: go to WAIT with drop=1.
- WAIT: drop=1. If rvalid arrives in the same cycle as the redirect, the data is discarded and the state goes to FETCH.
- HOLD: buffer discarded, go to FETCH.

Arithmetic and timing:
- All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Throughput is one instruction per (grant latency + rvalid latency + 1) cycles. No request is issued while WAIT or HOLD is active.
- imem_addr is driven from the pc register only, never combinationally from redirect_pc.

Decomposition:
- Shared defines file:
  - NOP_INST encoding.
  - State encodings FETCH=2'd0, WAIT=2'd1, HOLD=2'd2.
  - RESET_PC default.
- One sub-module: ifid_reg. It is the IF/ID pipeline register with load, hold and flush inputs and NOP insertion, reused by later pipeline registers.
- The FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset then release, gnt=1 each cycle, rvalid one cycle later, rdata=32'h00500093:
  - imem_addr=0 first.
  - ifid_inst=32'h00500093, ifid_pc=0, ifid_pc_plus4=4, ifid_valid=1.
  - Next request addr=4.
- id_stall held 3 cycles while the second word 32'h00A00113 returns:
  - IF/ID keeps the first instruction; state HOLD; no imem_req.
  - On stall release, ifid_inst=32'h00A00113, ifid_pc=4.
- redirect_valid with redirect_pc=32'h0000_0102 while in WAIT:
  - ifid_valid=0, ifid_inst=32'h00000013 the next cycle.
  - The returning word is discarded.
  - Next imem_addr=32'h0000_0100.
- redirect in the same cycle as imem_gnt in FETCH:
  - The response for the old PC is dropped; next request addr=redirect target.
- redirect while id_stall=1 and ifid_valid=1:
  - Flush wins: ifid_valid=0 next cycle.
- PC wrap:
  - redirect_pc=32'hFFFF_FFFC, fetch completes → ifid_pc_plus4=0, next imem_addr=0.
- rst_n pulsed low while in WAIT:
  - All outputs return to reset values immediately (asynchronous); imem_req=0.
